// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
// Optional statistics hardware in fifo_wr_arbiter is enabled by defining ARB_STATS_EN.
package fifo_arb_pkg;

  // ARB: round-robin selection between requesters.
  // HOLD: the port is locked to one owner for a burst.
  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Index width for a set of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: finds the first active request at or after ptr,
// wrapping modulo NREQ, and returns it as a one-hot vector and an index.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   winner,
  output logic            any
);

  // Walk the requesters starting at ptr; the first active one wins.
  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[(int'(ptr) + k) % NREQ]) begin
        any                          = 1'b1;
        winner                       = PW'((int'(ptr) + k) % NREQ);
        gnt[(int'(ptr) + k) % NREQ]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single fifo write port among NREQ requesters.
// Round-robin per word, with optional locked bursts of up to MAX_BURST words.
// Grant, WREQ and WD are combinational, so an uncontended word moves in the
// same cycle it is requested. Define ARB_STATS_EN to add saturating
// per-requester transfer counters and a full-stall counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*DW-1:0]   wd_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 WREQ,
  output logic [DW-1:0]        WD,
  input  logic                 f
`ifdef ARB_STATS_EN
  ,
  output logic [NREQ*CNTW-1:0] stat_gnt,
  output logic [CNTW-1:0]      stat_stall
`endif
);

  localparam int PW = idx_w(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [BW-1:0]   bcnt;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_winner;
  logic            pick_any;
  logic [NREQ-1:0] xfer_vec;

  fifo_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .gnt    (pick_gnt),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Grant is suppressed in reset and while the fifo is full; in HOLD only the owner may win.
  always_comb begin
    gnt = '0;
    if (rst && !f) begin
      if (state == ARB) begin
        if (pick_any) gnt = pick_gnt;
      end else if (req[owner]) begin
        gnt[owner] = 1'b1;
      end
    end
  end

  assign xfer_vec = req & gnt;
  assign WREQ     = |xfer_vec;

  // Steer the granted requester's slice onto the fifo data bus, zero when idle.
  always_comb begin
    WD = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer_vec[i]) WD = wd_in[i*DW +: DW];
    end
  end

  // Arbitration FSM: pointer advance, burst entry, burst counting and release; everything freezes while full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
      bcnt  <= '0;
    end else if (!f) begin
      case (state)
        ARB: begin
          if (WREQ) begin
            ptr <= (pick_winner == PW'(NREQ - 1)) ? '0 : pick_winner + PW'(1);
            if (lock[pick_winner] && (MAX_BURST > 1)) begin
              state <= HOLD;
              owner <= pick_winner;
              bcnt  <= BW'(1);
            end
          end
        end
        HOLD: begin
          if (req[owner]) begin
            if (lock[owner] && (int'(bcnt) + 1 < MAX_BURST)) begin
              bcnt <= bcnt + BW'(1);
            end else begin
              state <= ARB;
              bcnt  <= '0;
            end
          end else begin
            state <= ARB;
            bcnt  <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating counters for transfers per requester and for cycles stalled on a full fifo.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_gnt   <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer_vec[i] && (stat_gnt[i*CNTW +: CNTW] != {CNTW{1'b1}})) begin
          stat_gnt[i*CNTW +: CNTW] <= stat_gnt[i*CNTW +: CNTW] + CNTW'(1);
        end
      end
      if ((|req) && f && (stat_stall != {CNTW{1'b1}})) begin
        stat_stall <= stat_stall + CNTW'(1);
      end
    end
  end
`else
  // This build carries no statistics hardware.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (NREQ=4, DW=8, MAX_BURST=4).
// Statistics checks are included when ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CNTW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [NREQ*DW-1:0]   wd_in;
  logic [NREQ-1:0]      gnt;
  logic                 WREQ;
  logic [DW-1:0]        WD;
  logic                 f;
`ifdef ARB_STATS_EN
  logic [NREQ*CNTW-1:0] stat_gnt;
  logic [CNTW-1:0]      stat_stall;
`endif

  int tests = 0;
  int fails = 0;

  // Locked-burst scenario: requester 1 sends six words, the first five locked.
  logic [3:0] t3_req  [11] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                               4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1101};
  logic [3:0] t3_lock [11] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                               4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
  logic [7:0] t3_s1   [11] = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
                               8'h14, 8'h14, 8'h14, 8'h15, 8'h15};
  logic [3:0] t3_gnt  [11] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                               4'b1000, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
  logic [7:0] t3_wd   [11] = '{8'hA0, 8'h10, 8'h11, 8'h12, 8'h13, 8'hC2,
                               8'hD3, 8'hA0, 8'h14, 8'h15, 8'hC2};

  // End-to-end fifo model state.
  logic [7:0] fifo_q  [$];
  logic [7:0] log_q   [$];
  int         log_idx [$];
  int         cnt     [3];

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .MAX_BURST (4),
    .CNTW      (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .wd_in      (wd_in),
    .gnt        (gnt),
    .WREQ       (WREQ),
    .WD         (WD),
    .f          (f)
`ifdef ARB_STATS_EN
    ,
    .stat_gnt   (stat_gnt),
    .stat_stall (stat_stall)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_gnt, input logic exp_wreq,
                             input logic [7:0] exp_wd);
    checkValue({tag, "_gnt"},  32'(gnt),  32'(exp_gnt));
    checkValue({tag, "_wreq"}, 32'(WREQ), 32'(exp_wreq));
    checkValue({tag, "_wd"},   32'(WD),   32'(exp_wd));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic ff);
    req  = r;
    lock = l;
    f    = ff;
    #1;
  endtask

  task automatic setSlice(input int i, input logic [7:0] d);
    wd_in[i*DW +: DW] = d;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulseReset;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic setBaseData;
    setSlice(0, 8'hA0);
    setSlice(1, 8'hB1);
    setSlice(2, 8'hC2);
    setSlice(3, 8'hD3);
  endtask

  initial begin
    rst = 1'b0;
    setBaseData();
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkOutput("reset", 4'b0000, 1'b0, 8'h00);
`ifdef ARB_STATS_EN
    checkValue("reset_stall", 32'(stat_stall), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Test 1: all four requesting, plain round robin 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b0);
      checkOutput("t1_rr", 4'(1 << (k % 4)), 1'b1, 8'(8'hA0 + 8'h11 * (k % 4)));
      tick();
    end

    // Test 2: only 0 and 2 request from ptr=0, grants alternate.
    pulseReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0101, 4'b0000, 1'b0);
      if (k % 2 == 0) checkOutput("t2_alt", 4'b0001, 1'b1, 8'hA0);
      else            checkOutput("t2_alt", 4'b0100, 1'b1, 8'hC2);
      tick();
    end

    // Test 3: locked burst from requester 1, forced release at four words, then resume.
    pulseReset();
    for (int k = 0; k < 11; k++) begin
      setSlice(1, t3_s1[k]);
      applyStimulus(t3_req[k], t3_lock[k], 1'b0);
      checkOutput("t3_burst", t3_gnt[k], 1'b1, t3_wd[k]);
      tick();
    end

    // Test 4: fifo full for five cycles, then the held pointer (3) wins.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      checkOutput("t4_full", 4'b0000, 1'b0, 8'h00);
      tick();
    end
`ifdef ARB_STATS_EN
    checkValue("t4_stall", 32'(stat_stall), 32'd5);
`endif
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkOutput("t4_resume", 4'b1000, 1'b1, 8'hD3);
    tick();
`ifdef ARB_STATS_EN
    checkValue("t4_stat0", 32'(stat_gnt[0*CNTW +: CNTW]), 32'd2);
    checkValue("t4_stat1", 32'(stat_gnt[1*CNTW +: CNTW]), 32'd6);
    checkValue("t4_stat2", 32'(stat_gnt[2*CNTW +: CNTW]), 32'd2);
    checkValue("t4_stat3", 32'(stat_gnt[3*CNTW +: CNTW]), 32'd2);
`endif

    // Test 5: owner abandons a burst, then reset lands in the middle of another.
    setBaseData();
    applyStimulus(4'b1111, 4'b0001, 1'b0);
    checkOutput("t5_lock0", 4'b0001, 1'b1, 8'hA0);
    tick();
    applyStimulus(4'b1110, 4'b0001, 1'b0);
    checkOutput("t5_drop", 4'b0000, 1'b0, 8'h00);
    tick();
    applyStimulus(4'b1110, 4'b0000, 1'b0);
    checkOutput("t5_next", 4'b0010, 1'b1, 8'hB1);
    tick();
    applyStimulus(4'b1111, 4'b0100, 1'b0);
    checkOutput("t5_lock2", 4'b0100, 1'b1, 8'hC2);
    tick();
    applyStimulus(4'b1111, 4'b0100, 1'b0);
    checkOutput("t5_hold2", 4'b0100, 1'b1, 8'hC2);
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_mid", 4'b0000, 1'b0, 8'h00);
    tick();
`ifdef ARB_STATS_EN
    checkValue("t5_stall_clr", 32'(stat_stall), 32'd0);
    checkValue("t5_stat1_clr", 32'(stat_gnt[1*CNTW +: CNTW]), 32'd0);
`endif
    rst = 1'b1;
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    checkOutput("t5_after_rst", 4'b0001, 1'b1, 8'hA0);
    tick();

    // Test 6: three requesters fill a six-deep fifo model, then drain and compare.
    pulseReset();
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int c = 0; c < 40 && fifo_q.size() < 6; c++) begin
      int  g;
      logic wrote;
      g = 0;
      for (int i = 0; i < 3; i++) setSlice(i, 8'((i << 6) | cnt[i]));
      setSlice(3, 8'hFF);
      applyStimulus(4'b0111, 4'b0000, 1'b0);
      wrote = WREQ;
      if (wrote) begin
        checkValue("t6_onehot", 32'($onehot(gnt)), 32'd1);
        for (int j = 0; j < 3; j++) if (gnt[j]) g = j;
        log_q.push_back(8'((g << 6) | cnt[g]));
        log_idx.push_back(g);
        fifo_q.push_back(WD);
      end
      tick();
      if (wrote) cnt[g]++;
    end
    checkValue("t6_fill", 32'(fifo_q.size()), 32'd6);
    applyStimulus(4'b0111, 4'b0000, 1'b1);
    checkOutput("t6_full", 4'b0000, 1'b0, 8'h00);
    tick();
    for (int k = 0; k < log_idx.size(); k++) begin
      checkValue("t6_order", 32'(log_idx[k]), 32'(k % 3));
    end
    while (fifo_q.size() > 0 && log_q.size() > 0) begin
      checkValue("t6_data", 32'(fifo_q.pop_front()), 32'(log_q.pop_front()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
